// File: rtl/protocol_cycle_acquirer.sv
// Frames debounced indicator-high windows and accumulates signed data over each,
// handing {sum, count, sat} to a reader through a valid/ready register stage.
module protocol_cycle_acquirer #(
    parameter int DATA_W   = 14,
    parameter int CNT_W    = 24,
    parameter int ACC_W    = 38,
    parameter int DEBOUNCE = 4
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic                     enable_i,
    input  logic signed [DATA_W-1:0] data_i,
    input  logic signed [DATA_W-1:0] indicator_i,
    input  logic signed [DATA_W-1:0] threshold_i,
    output logic signed [ACC_W-1:0]  sum_o,
    output logic        [CNT_W-1:0]  count_o,
    output logic                     sat_o,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic                     missed_o
);

    localparam int             DB_W    = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {IDLE, ARM_LOW, WAIT_HIGH, ACCUM} state_t;

    state_t                  st_q;
    logic                    ind_q, ind_d;
    logic [DB_W-1:0]         db_q, db_d;
    logic signed [ACC_W-1:0] acc_q, acc_d, data_ext;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    sat_q;
    logic                    raw;

    assign raw      = (indicator_i > threshold_i);
    assign data_ext = ACC_W'(data_i);
    assign acc_d    = acc_q + data_ext;
    assign cnt_d    = cnt_q + CNT_W'(1);

    // Level flips only after DEBOUNCE consecutive disagreeing samples.
    always_comb begin
        ind_d = ind_q;
        db_d  = '0;
        if (raw != ind_q) begin
            if (db_q == DB_LAST) ind_d = raw;
            else                 db_d  = db_q + DB_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            st_q     <= IDLE;
            ind_q    <= 1'b0;
            db_q     <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            sat_q    <= 1'b0;
            sum_o    <= '0;
            count_o  <= '0;
            sat_o    <= 1'b0;
            valid_o  <= 1'b0;
            missed_o <= 1'b0;
        end else begin
            ind_q    <= ind_d;
            db_q     <= db_d;
            missed_o <= 1'b0;
            if (valid_o && ready_i) valid_o <= 1'b0;

            if (!enable_i) begin
                st_q <= IDLE;
            end else begin
                case (st_q)
                    IDLE:      st_q <= ARM_LOW;
                    ARM_LOW:   if (!ind_q) st_q <= WAIT_HIGH;
                    WAIT_HIGH: if (ind_q) begin
                        acc_q <= data_ext;
                        cnt_q <= CNT_W'(1);
                        sat_q <= 1'b0;
                        st_q  <= ACCUM;
                    end
                    ACCUM: begin
                        if (ind_q) begin
                            // Counter pinned at max: freeze sum/count, remember it.
                            if (cnt_q == CNT_MAX) begin
                                sat_q <= 1'b1;
                            end else begin
                                acc_q <= acc_d;
                                cnt_q <= cnt_d;
                            end
                        end else begin
                            st_q <= WAIT_HIGH;
                            if (!valid_o || ready_i) begin
                                sum_o   <= acc_q;
                                count_o <= cnt_q;
                                sat_o   <= sat_q;
                                valid_o <= 1'b1;
                            end else begin
                                missed_o <= 1'b1;
                            end
                        end
                    end
                    default:   st_q <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_protocol_cycle_acquirer.sv
// Bench for protocol_cycle_acquirer: directed window table, hand sequences and
// random traffic, all checked against a queue-based window model.
module tb_protocol_cycle_acquirer;
    localparam int DW = 14, D = 4;
    localparam int CW_B = 24, AW_B = 38, CW_S = 4, AW_S = 18;

    logic clk = 1'b0, rstn = 1'b0, en = 1'b0, rdy = 1'b0;
    logic signed [DW-1:0] data = '0, ind = '0, thr = '0;
    logic signed [AW_B-1:0] sum_b;
    logic [CW_B-1:0] cnt_b;
    logic sat_b, vld_b, mis_b;
    logic signed [AW_S-1:0] sum_s;
    logic [CW_S-1:0] cnt_s;
    logic sat_s, vld_s, mis_s;

    always #5 clk = ~clk;

    protocol_cycle_acquirer #(.DATA_W(DW), .CNT_W(CW_B), .ACC_W(AW_B), .DEBOUNCE(D)) dut (
        .clk_i(clk), .rstn_i(rstn), .enable_i(en), .data_i(data), .indicator_i(ind),
        .threshold_i(thr), .sum_o(sum_b), .count_o(cnt_b), .sat_o(sat_b),
        .valid_o(vld_b), .ready_i(rdy), .missed_o(mis_b));

    protocol_cycle_acquirer #(.DATA_W(DW), .CNT_W(CW_S), .ACC_W(AW_S), .DEBOUNCE(D)) dut_s (
        .clk_i(clk), .rstn_i(rstn), .enable_i(en), .data_i(data), .indicator_i(ind),
        .threshold_i(thr), .sum_o(sum_s), .count_o(cnt_s), .sat_o(sat_s),
        .valid_o(vld_s), .ready_i(rdy), .missed_o(mis_s));

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: raw history decides the level; a window is the list of samples
    // seen while the level is high; the result truncates that list to the counter cap.
    bit     m_ind;
    bit     hist[$];
    int     phase;          // 0 disarmed, 1 waiting for low, 2 waiting for high, 3 in window
    int     win[$];
    bit     m_vld, m_mis;
    longint m_sum[2];
    longint m_cnt[2];
    bit     m_sat[2];

    function automatic longint cap(input int k);
        return (k == 0) ? ((longint'(1) << CW_B) - 1) : ((longint'(1) << CW_S) - 1);
    endfunction

    task automatic model_edge();
        bit raw, fin, take, all_diff;
        longint n, s;
        raw = ($signed(ind) > $signed(thr));
        if (!rstn) begin
            m_ind = 0; hist.delete(); phase = 0; win.delete();
            m_vld = 0; m_mis = 0;
            for (int k = 0; k < 2; k++) begin m_sum[k] = 0; m_cnt[k] = 0; m_sat[k] = 0; end
            return;
        end
        fin = 0;
        if (!en) begin
            phase = 0; win.delete();
        end else begin
            case (phase)
                0: phase = 1;
                1: if (!m_ind) phase = 2;
                2: if (m_ind) begin win.delete(); win.push_back(int'(data)); phase = 3; end
                default: if (m_ind) win.push_back(int'(data)); else begin fin = 1; phase = 2; end
            endcase
        end
        take = !m_vld || rdy;
        if (m_vld && rdy) m_vld = 0;
        m_mis = 0;
        if (fin) begin
            if (take) begin
                for (int k = 0; k < 2; k++) begin
                    n = (win.size() > cap(k)) ? cap(k) : longint'(win.size());
                    s = 0;
                    for (int i = 0; i < n; i++) s += win[i];
                    m_sum[k] = s; m_cnt[k] = n; m_sat[k] = (win.size() > cap(k));
                end
                m_vld = 1;
            end else m_mis = 1;
        end
        hist.push_back(raw);
        if (hist.size() > D) void'(hist.pop_front());
        if (hist.size() == D) begin
            all_diff = 1;
            foreach (hist[i]) if (hist[i] == m_ind) all_diff = 0;
            if (all_diff) m_ind = !m_ind;
        end
    endtask

    task automatic check_all();
        chk("valid_b", vld_b, m_vld);   chk("valid_s", vld_s, m_vld);
        chk("missed_b", mis_b, m_mis);  chk("missed_s", mis_s, m_mis);
        chk("sum_b", sum_b, m_sum[0]);  chk("count_b", cnt_b, m_cnt[0]);
        chk("sat_b", sat_b, m_sat[0]);  chk("sum_s", sum_s, m_sum[1]);
        chk("count_s", cnt_s, m_cnt[1]); chk("sat_s", sat_s, m_sat[1]);
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic wait_valid(input string nm);
        for (int i = 0; i < 40 && !vld_b; i++) step();
        chk(nm, vld_b, 1);
    endtask

    task automatic accept();
        rdy = 1; step(); rdy = 0;
        chk("accept_clears", vld_b, 0);
    endtask

    task automatic window(input int pre, input int len, input logic signed [DW-1:0] d);
        data = d;
        ind = 0; repeat (pre) step();
        ind = 200; repeat (len) step();
        ind = 0;
    endtask

    typedef struct {
        int thr, hi, lo, pre, len, dat;
        longint sb, cb, ss, cs;
        bit st;
    } vec_t;
    vec_t tv[7];

    int mcnt;
    int runleft, t, lvl;

    initial begin
        // raw high-run of L samples with DEBOUNCE=4 gives a window of exactly L samples
        tv[0] = '{100, 200, 0, 10, 20, 3, 60, 20, 45, 15, 1};
        tv[1] = '{100, 200, 0, 8, 5, -7, -35, 5, -35, 5, 0};
        tv[2] = '{-2, -1, -2, 8, 15, -2, -30, 15, -30, 15, 0};
        tv[3] = '{0, 1, 0, 8, 16, 1, 16, 16, 15, 15, 1};
        tv[4] = '{100, 200, 0, 8, 20, -2, -40, 20, -30, 15, 1};
        tv[5] = '{-100, 50, -100, 8, 4, 8191, 32764, 4, 32764, 4, 0};
        tv[6] = '{5, 6, 5, 8, 6, -8192, -49152, 6, -49152, 6, 0};

        rstn = 0; repeat (3) step();
        chk("rst_valid", vld_b, 0); chk("rst_sum", sum_b, 0);
        chk("rst_count", cnt_b, 0); chk("rst_missed", mis_b, 0);
        rstn = 1; en = 1;

        foreach (tv[r]) begin
            thr = DW'(tv[r].thr); data = DW'(tv[r].dat);
            ind = DW'(tv[r].lo); repeat (tv[r].pre) step();
            ind = DW'(tv[r].hi); repeat (tv[r].len) step();
            ind = DW'(tv[r].lo);
            wait_valid($sformatf("vec%0d_valid", r));
            repeat (3) step();
            chk($sformatf("vec%0d_held", r), vld_b, 1);
            chk($sformatf("vec%0d_sum_b", r), sum_b, tv[r].sb);
            chk($sformatf("vec%0d_cnt_b", r), cnt_b, tv[r].cb);
            chk($sformatf("vec%0d_sat_b", r), sat_b, 0);
            chk($sformatf("vec%0d_sum_s", r), sum_s, tv[r].ss);
            chk($sformatf("vec%0d_cnt_s", r), cnt_s, tv[r].cs);
            chk($sformatf("vec%0d_sat_s", r), sat_s, tv[r].st);
            accept();
        end

        // glitch shorter than the debounce length
        thr = 100; ind = 0; repeat (8) step();
        ind = 200; repeat (3) step();
        ind = 0; repeat (15) step();
        chk("glitch_no_valid", vld_b, 0);

        // armed while already high: that window is skipped
        en = 0; ind = 200; data = 9; repeat (8) step();
        en = 1; repeat (10) step();
        window(8, 6, 5);
        wait_valid("late_arm_valid");
        chk("late_arm_sum", sum_b, 30); chk("late_arm_cnt", cnt_b, 6);
        accept();

        // two windows with no reader: second is dropped and flagged once
        window(8, 5, 2);
        repeat (8) step();
        chk("bb_first_valid", vld_b, 1);
        mcnt = 0;
        data = 9; ind = 200; repeat (7) step();
        ind = 0;
        for (int i = 0; i < 12; i++) begin step(); mcnt += int'(mis_b); end
        chk("bb_missed_once", mcnt, 1);
        chk("bb_sum_kept", sum_b, 10); chk("bb_cnt_kept", cnt_b, 5);
        accept();

        // enable drop mid-window with a pending result
        window(8, 5, 4);
        wait_valid("en_pending_valid");
        ind = 200; data = 7; repeat (8) step();
        en = 0; repeat (2) step(); en = 1;
        mcnt = 0;
        ind = 0;
        for (int i = 0; i < 10; i++) begin step(); mcnt += int'(mis_b); end
        chk("en_drop_no_missed", mcnt, 0);
        chk("en_drop_valid", vld_b, 1); chk("en_drop_sum", sum_b, 20);
        accept();
        window(8, 9, -3);
        wait_valid("en_rearm_valid");
        chk("en_rearm_sum", sum_b, -27); chk("en_rearm_cnt", cnt_b, 9);

        // reset mid-window discards result and pending state
        ind = 200; data = 1; repeat (8) step();
        rstn = 0; step();
        chk("midrst_valid", vld_b, 0); chk("midrst_sum", sum_b, 0); chk("midrst_cnt", cnt_b, 0);
        rstn = 1; ind = 0; repeat (10) step();
        window(8, 6, 11);
        wait_valid("post_rst_valid");
        chk("post_rst_sum", sum_b, 66); chk("post_rst_cnt", cnt_b, 6);
        accept();

        // random traffic against the model
        runleft = 0; lvl = 0; t = 0; thr = 0;
        for (int c = 0; c < 4000; c++) begin
            if (runleft == 0) begin lvl = 1 - lvl; runleft = int'($urandom_range(1, 24)); end
            runleft--;
            if ($urandom_range(0, 49) == 0) begin
                t = int'($urandom_range(0, 16000)) - 8000;
                thr = DW'(t);
            end
            if (lvl == 1) ind = DW'(t + int'($urandom_range(1, 3)));
            else          ind = DW'(t - int'($urandom_range(0, 2)));
            data = DW'($urandom());
            if (c % 150 < 60) rdy = 1'b0;
            else              rdy = ($urandom_range(0, 3) != 0);
            en   = ($urandom_range(0, 199) != 0);
            rstn = ($urandom_range(0, 999) != 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
